bf_response_checker: RTL



---
 rtl/bf_response_checker_pkg.sv | 18 +
 rtl/bf_settle_timer.sv | 44 ++++
 rtl/bf_response_checker.sv | 106 ++++++++++
 3 files changed

// File: rtl/bf_response_checker_pkg.sv
// Shared types and helpers for the Boolean-function response checker.
// The truth table packs {D,E} for input {A,B,C} at bits [2i+1:2i].
package bf_response_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full adder: D = sum, E = carry
    localparam logic [15:0] DEF_EXP_TABLE = 16'hD668;

    function automatic logic [1:0] exp_lookup(input logic [15:0] tbl, input logic [2:0] idx);
        return tbl[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/bf_settle_timer.sv
// Per-vector stability timer: restarts on every vector change and issues one
// sample_now strobe once the vector has stayed put for SETTLE cycles.
module bf_settle_timer #(
    parameter int SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       en,
    input  logic [2:0] vec_in,
    output logic       sample_now
);

    logic [3:0] settle_cnt;
    logic [2:0] last_vec;
    logic       sampled;
    logic       changed;

    assign changed    = (vec_in != last_vec);
    assign sample_now = en && !changed && (settle_cnt == 4'd0) && !sampled;

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= 4'd0;
            last_vec   <= 3'd0;
            sampled    <= 1'b0;
        end else if (init) begin
            settle_cnt <= 4'(SETTLE);
            last_vec   <= vec_in;
            sampled    <= 1'b0;
        end else if (en) begin
            if (changed) begin
                settle_cnt <= 4'(SETTLE);
                last_vec   <= vec_in;
                sampled    <= 1'b0;
            end else if (settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end else if (!sampled) begin
                sampled <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bf_response_checker.sv
// Response checker for 3-in/2-out Boolean function blocks: samples each settled
// vector once, compares against EXP_TABLE and reports coverage/mismatch stats.
//
// state | meaning
// IDLE  | waiting for the first start pulse
// RUN   | sampling vectors, counting toward TIMEOUT
// DONE  | result held until start or rst
module bf_response_checker
    import bf_response_checker_pkg::*;
#(
    parameter logic [15:0] EXP_TABLE = DEF_EXP_TABLE,
    parameter int          SETTLE    = 4,
    parameter int          TIMEOUT   = 1024,
    parameter int          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       vec_in,
    input  logic [1:0]       resp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       cov_map,
    output logic             first_err_valid,
    output logic [2:0]       first_err_vec,
    output logic [1:0]       first_err_resp
);

    localparam int TW = $clog2(TIMEOUT);

    state_t           state, state_nx;
    logic [TW-1:0]    t_cnt;
    logic             in_run, start_run, sample_now, mismatch;
    logic             cov_full, t_expired;
    logic [7:0]       cov_nx;
    logic [CNT_W-1:0] err_nx;

    assign in_run    = (state == RUN);
    assign start_run = start && !in_run;
    assign busy      = in_run;
    assign done      = (state == DONE);

    bf_settle_timer #(.SETTLE(SETTLE)) u_settle (
        .clk        (clk),
        .rst        (rst),
        .init       (start_run),
        .en         (in_run),
        .vec_in     (vec_in),
        .sample_now (sample_now)
    );

    assign mismatch  = sample_now && (resp_in != exp_lookup(EXP_TABLE, vec_in));
    assign cov_nx    = cov_map | (sample_now ? (8'd1 << vec_in) : 8'd0);
    assign err_nx    = (mismatch && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
    assign cov_full  = (cov_nx == 8'hFF);
    assign t_expired = (t_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cov_full || t_expired) state_nx = DONE;
            DONE:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            t_cnt           <= '0;
            err_cnt         <= '0;
            cov_map         <= 8'd0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 3'd0;
            first_err_resp  <= 2'd0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
        end else if (in_run) begin
            t_cnt   <= t_cnt + 1'b1;
            cov_map <= cov_nx;
            err_cnt <= err_nx;
            if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_vec   <= vec_in;
                first_err_resp  <= resp_in;
            end
            // Coverage completing on the final timeout cycle still counts as a clean finish
            if (cov_full) begin
                pass    <= (err_nx == '0);
                timeout <= 1'b0;
            end else if (t_expired) begin
                pass    <= 1'b0;
                timeout <= 1'b1;
            end
        end
    end

endmodule
